// File: rtl/mdr_mem_ctrl_if.sv
// rtl/mdr_mem_ctrl_if.sv - request, memory handshake and MAR/MDR control signals of mdr_mem_ctrl
interface mdr_mem_ctrl_if;
    logic rd_req;
    logic wr_req;
    logic mem_ready;
    logic MARin;
    logic MDRin;
    logic Read;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    modport master (
        output rd_req, wr_req, mem_ready,
        input  MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err
    );

    modport slave (
        input  rd_req, wr_req, mem_ready,
        output MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err
    );
endinterface

// File: rtl/mdr_mem_ctrl.sv
// rtl/mdr_mem_ctrl.sv - MAR/MDR and memory strobe sequencer with ready timeout
module mdr_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           clr,
    mdr_mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_RD_WAIT, S_RD_LATCH, S_WR_LOAD, S_WR_WAIT, S_FIN, S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           nxt;
    logic             dir_wr;
    logic [CNT_W-1:0] cnt;
    logic             nxt_is_wait;
    logic             cur_is_wait;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (bus.rd_req || bus.wr_req) nxt = S_ADDR;
            S_ADDR:     nxt = dir_wr ? S_WR_LOAD : S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.mem_ready)        nxt = S_RD_LATCH;
                else if (cnt >= CNT_LAST) nxt = S_ERR;
            end
            S_RD_LATCH: nxt = S_FIN;
            S_WR_LOAD:  nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.mem_ready)        nxt = S_FIN;
                else if (cnt >= CNT_LAST) nxt = S_ERR;
            end
            S_FIN:      nxt = S_IDLE;
            S_ERR:      nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    assign nxt_is_wait = (nxt == S_RD_WAIT) || (nxt == S_WR_WAIT);
    assign cur_is_wait = (state == S_RD_WAIT) || (state == S_WR_WAIT);

    // Outputs are registered from the next state, so they always reflect the state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= S_IDLE;
            dir_wr     <= 1'b0;
            cnt        <= '0;
            bus.MARin  <= 1'b0;
            bus.MDRin  <= 1'b0;
            bus.Read   <= 1'b0;
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            state <= nxt;
            // Read wins a simultaneous request, so the direction is write only when rd_req is low.
            if (state == S_IDLE && nxt == S_ADDR)
                dir_wr <= ~bus.rd_req;

            if (nxt_is_wait && nxt != state)
                cnt <= '0;
            else if (cur_is_wait && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            bus.MARin  <= (nxt == S_ADDR);
            bus.MDRin  <= (nxt == S_RD_LATCH) || (nxt == S_WR_LOAD);
            bus.Read   <= (nxt == S_RD_WAIT) || (nxt == S_RD_LATCH);
            bus.mem_rd <= (nxt == S_RD_WAIT) || (nxt == S_RD_LATCH);
            bus.mem_wr <= (nxt == S_WR_WAIT);
            bus.busy   <= (nxt != S_IDLE);
            bus.done   <= (nxt == S_FIN) || (nxt == S_ERR);
            bus.err    <= (nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb/tb_mdr_mem_ctrl.sv - randomized self-checking bench for mdr_mem_ctrl
module tb_mdr_mem_ctrl;

    localparam int T = 16;

    localparam logic [7:0] V_BUSY  = 8'h80;
    localparam logic [7:0] V_DONE  = 8'h40;
    localparam logic [7:0] V_ERR   = 8'h20;
    localparam logic [7:0] V_WR    = 8'h10;
    localparam logic [7:0] V_RD    = 8'h08;
    localparam logic [7:0] V_READ  = 8'h04;
    localparam logic [7:0] V_MDRIN = 8'h02;
    localparam logic [7:0] V_MARIN = 8'h01;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    mdr_mem_ctrl_if bus ();

    mdr_mem_ctrl #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.busy, bus.done, bus.err, bus.mem_wr, bus.mem_rd, bus.Read, bus.MDRin, bus.MARin};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Expected per-cycle output vectors of one access whose memory answers after w idle wait cycles.
    task automatic build_trace(input bit wr, input int w, output logic [7:0] tr[$]);
        int nwait;
        tr = {};
        tr.push_back(V_BUSY | V_MARIN);
        if (wr) tr.push_back(V_BUSY | V_MDRIN);
        nwait = (w >= T) ? T : w + 1;
        for (int i = 0; i < nwait; i++)
            tr.push_back(wr ? (V_BUSY | V_WR) : (V_BUSY | V_RD | V_READ));
        if (w >= T) begin
            tr.push_back(V_BUSY | V_DONE | V_ERR);
        end else begin
            if (!wr) tr.push_back(V_BUSY | V_RD | V_READ | V_MDRIN);
            tr.push_back(V_BUSY | V_DONE);
        end
    endtask

    // Entered at a negedge in IDLE with the request(s) already driven; leaves at a negedge in IDLE.
    task automatic do_access(input bit wr, input int w, input bit hold_other, input string name);
        logic [7:0] tr[$];
        int widx;
        build_trace(wr, w, tr);
        for (int k = 0; k < tr.size(); k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_c%0d", name, k + 1), outs(), tr[k]);
            widx = k - (wr ? 2 : 1);
            if (widx >= 0 && widx == w)     bus.mem_ready = 1'b1;
            else if (widx >= 0 && widx < w) bus.mem_ready = 1'b0;
            else                            bus.mem_ready = 1'($urandom_range(0, 1));
            if (k == tr.size() - 1) begin
                if (wr) begin
                    bus.wr_req = 1'b0;
                    bus.rd_req = hold_other;
                end else begin
                    bus.rd_req = 1'b0;
                    bus.wr_req = hold_other;
                end
            end else if (!hold_other) begin
                if (wr) bus.rd_req = 1'($urandom_range(0, 1));
                else    bus.wr_req = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk);
        @(negedge clk);
        check({name, "_idle"}, outs(), 8'h00);
    endtask

    initial begin
        int w;
        bit wr;
        n_checks = 0;
        n_pass   = 0;
        clr = 1'b0;
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_c%0d", i), outs(), 8'h00);
        end
        clr = 1'b1;
        do_access(1'b0, 0, 1'b0, "rd_zero_wait");

        bus.wr_req = 1'b1;
        do_access(1'b1, 3, 1'b0, "wr_3wait");

        bus.rd_req = 1'b1;
        do_access(1'b0, 100, 1'b0, "rd_timeout");

        bus.wr_req = 1'b1;
        do_access(1'b1, T - 1, 1'b0, "wr_last_wait");

        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        do_access(1'b0, 1, 1'b1, "both_rd");
        do_access(1'b1, 2, 1'b0, "both_wr");

        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 3))
                                              : int'($urandom_range(0, 5));
            bus.rd_req = ~wr;
            bus.wr_req = wr;
            do_access(wr, w, 1'b0, $sformatf("rnd%0d_%s_w%0d", i, wr ? "wr" : "rd", w));
        end

        bus.rd_req = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_addr", outs(), V_BUSY | V_MARIN);
        bus.rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_rdwait", outs(), V_BUSY | V_RD | V_READ);
        #2;
        clr = 1'b0;
        #1;
        check("abort_async", outs(), 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("abort_hold%0d", i), outs(), 8'h00);
        end
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("abort_after%0d", i), outs(), 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
